fft_frame_arbiter: RTL and testbench
====================================

// Module: fft_frame_arbiter
// PURPOSE
// Shares one fft_core instance between NUM_CH real-sample ADC streams at frame granularity.
// - Grants the core to one channel at a time, round-robin.
// - Forwards exactly FFT_SIZE input samples from that channel, then drains exactly FFT_SIZE
//   complex results from the core to a single output stream tagged with the channel index.
// - Sits between the per-channel ADC front-ends and the fft_core ADC/FFT-output handshakes.
// PARAMETERS
// NUM_CH      4     number of ADC requester channels (>=2)
// FFT_SIZE    1024  samples per frame; power of two, matches fft_core FFT_SIZE
// DATA_WIDTH  16    real sample width; complex result is 2*DATA_WIDTH
// CH_W        $clog2(NUM_CH)  derived localparam, channel-index width
// PORTS
// clk_i            in   1                clock
// rst_ni           in   1                reset, asynchronous, active-low
// enable_i         in   1                permit new grants; frame in progress always completes
// ch_data_i        in   NUM_CH*DATA_WIDTH  per-channel signed samples, ch k at [k*DW +: DW]
// ch_valid_i       in   NUM_CH           per-channel sample valid
// ch_ready_o       out  NUM_CH           per-channel ready; only granted channel may be 1
// fft_adc_data_o   out  DATA_WIDTH       sample to fft_core adc_data_i
// fft_adc_valid_o  out  1                to fft_core adc_valid_i
// fft_adc_ready_i  in   1                from fft_core adc_ready_o
// fft_res_data_i   in   2*DATA_WIDTH     from fft_core fft_out_data_o {re,im}
// fft_res_valid_i  in   1                from fft_core fft_out_valid_o
// fft_res_ready_o  out  1                to fft_core fft_out_ready_i
// out_data_o       out  2*DATA_WIDTH     tagged result {re,im}
// out_ch_o         out  CH_W             channel index owning out_data_o
// out_last_o       out  1                marks result beat FFT_SIZE-1 of the frame
// out_valid_o      out  1                result valid
// out_ready_i      in   1                downstream ready
// busy_o           out  1                high in FEED or DRAIN
// err_o            out  1                one-cycle pulse: fft_res_valid_i seen outside DRAIN
// BEHAVIOUR
// - Reset values: state IDLE, grant=0, last_grant=NUM_CH-1, counters 0; all outputs 0.
//   Reset mid-frame abandons the frame; no partial completion.
// - FSM states: IDLE, FEED, DRAIN.
// - IDLE: if enable_i && |ch_valid_i, pick the first valid channel searching last_grant+1
//   upward with wrap. Latch it as grant and go to FEED next cycle. No data moves in IDLE.
// - FEED, combinational pass-through, zero latency:
//   - fft_adc_data_o = ch_data_i[grant].
//   - fft_adc_valid_o = ch_valid_i[grant].
//   - ch_ready_o[grant] = fft_adc_ready_i; all other ch_ready_o = 0.
//   - in_cnt increments on each fft_adc_valid_o && fft_adc_ready_i.
//   - The handshake that makes in_cnt reach FFT_SIZE-1->wrap moves the FSM to DRAIN.
//   - The sample after the frame is never accepted.
// - DRAIN, combinational pass-through:
//   - out_valid_o = fft_res_valid_i, fft_res_ready_o = out_ready_i.
//   - out_data_o = fft_res_data_i, out_ch_o = grant.
//   - out_last_o = out_valid_o && out_cnt==FFT_SIZE-1.
//   - out_cnt increments on each out_valid_o && out_ready_i.
//   - The last handshake sets last_grant<=grant, clears counters and goes to IDLE.
//     If enable_i is still high, a new grant is evaluated the following cycle.
// - Outside DRAIN: out_valid_o=0, fft_res_ready_o=0.
//   - fft_res_valid_i=1 raises err_o for that cycle.
//   - The FSM state is unaffected by this error.
// - Outside FEED: fft_adc_valid_o=0 and all ch_ready_o=0.
//   Non-granted channels are always back-pressured.
// - enable_i low affects only IDLE grant decisions. A started frame completes both FEED and DRAIN.
// - Counters are $clog2(FFT_SIZE) bits and wrap to 0 exactly at the frame boundary.
// - Channel valid dropping mid-FEED stalls the frame; there is no timeout.
// - busy_o = (state != IDLE).
// TESTING (bench uses NUM_CH=4, FFT_SIZE=8, DATA_WIDTH=16; fft_core model or stub)
// 1. Only ch2 valid, samples 1..8, out_ready_i=1:
//    - 8 input handshakes on ch2; ch0/1/3 ready stay 0.
//    - 8 results with out_ch_o=2 and out_last_o on beat 8.
//    - Then IDLE and busy_o=0.
// 2. All channels continuously valid, 4 frames:
//    - Grant order is 0,1,2,3.
//    - A 5th frame is granted to 0; after the first frame's wrap last_grant=0.
// 3. fft_adc_ready_i low for 3 cycles mid-FEED at sample 5 -> in_cnt holds at 4;
//    exactly 8 samples accepted total; sample 9 of the channel is not consumed.
// 4. out_ready_i toggled 1/0 each cycle in DRAIN:
//    - fft_res_ready_o mirrors it.
//    - 8 handshakes complete the frame, out_last_o only on the 8th.
// 5. Clear enable_i at FEED sample 3:
//    - The frame finishes fully through DRAIN.
//    - Afterwards the FSM stays IDLE with valids high until enable_i returns.
// 6. fft_res_valid_i pulsed during FEED -> err_o=1 for exactly that cycle, out_valid_o=0.
//    Assert rst_ni mid-DRAIN -> all outputs 0 at once, and the next grant starts from ch0.

Source files
------------

// File: rtl/fft_frame_arbiter.sv
// fft_frame_arbiter
// Time-shares one fft_core between NUM_CH real-sample ADC streams, one whole
// frame at a time. The winning channel's FFT_SIZE samples are passed straight
// through to the core. The core's FFT_SIZE results are then passed straight
// through to a single output stream, tagged with the owning channel.
//
// Ports
//   clk_i, rst_ni          clock; asynchronous active-low reset
//   enable_i               allows new grants (a started frame always completes)
//   ch_data_i/_valid_i     per-channel samples (ch k at [k*DW +: DW])
//   ch_ready_o             per-channel ready; only the granted channel, only in FEED
//   fft_adc_*              sample handshake towards fft_core
//   fft_res_*              result handshake from fft_core ({re,im})
//   out_data_o/_ch_o       tagged result stream
//   out_last_o/_valid_o    end-of-frame marker and valid
//   out_ready_i            downstream ready
//   busy_o                 frame in progress (FEED or DRAIN)
//   err_o                  core presented a result outside DRAIN (that cycle)
module fft_frame_arbiter #(
    parameter int NUM_CH     = 4,
    parameter int FFT_SIZE   = 1024,
    parameter int DATA_WIDTH = 16,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         enable_i,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data_i,
    input  logic [NUM_CH-1:0]            ch_valid_i,
    output logic [NUM_CH-1:0]            ch_ready_o,
    output logic [DATA_WIDTH-1:0]        fft_adc_data_o,
    output logic                         fft_adc_valid_o,
    input  logic                         fft_adc_ready_i,
    input  logic [2*DATA_WIDTH-1:0]      fft_res_data_i,
    input  logic                         fft_res_valid_i,
    output logic                         fft_res_ready_o,
    output logic [2*DATA_WIDTH-1:0]      out_data_o,
    output logic [CH_W-1:0]              out_ch_o,
    output logic                         out_last_o,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic                         busy_o,
    output logic                         err_o
);

    localparam int CNT_W = (FFT_SIZE > 1) ? $clog2(FFT_SIZE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FFT_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state;
    logic [CH_W-1:0]       grant;
    logic [CH_W-1:0]       last_grant;
    logic [CNT_W-1:0]      in_cnt;
    logic [CNT_W-1:0]      out_cnt;

    logic [CH_W-1:0]       pick_idx;
    logic                  pick_found;
    int                    cand;
    logic                  in_feed;
    logic                  in_drain;
    logic                  in_hs;
    logic                  out_hs;
    logic [DATA_WIDTH-1:0] ch_sample [NUM_CH];

    // Split the flat sample bus so the granted channel can be selected by index.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign ch_sample[gi]  = ch_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
        assign ch_ready_o[gi] = in_feed && (grant == CH_W'(gi)) && fft_adc_ready_i;
    end

    // Round-robin search starting just after last_grant. The loop runs from
    // the farthest offset to the nearest so the nearest valid channel wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int i = NUM_CH; i >= 1; i--) begin
            cand = int'(last_grant) + i;
            if (cand >= NUM_CH) begin
                cand = cand - NUM_CH;
            end
            if (ch_valid_i[CH_W'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = CH_W'(cand);
            end
        end
    end

    assign in_feed  = (state == FEED);
    assign in_drain = (state == DRAIN);

    // Zero-latency pass-through in both directions, gated by state.
    assign fft_adc_data_o  = in_feed ? ch_sample[grant] : '0;
    assign fft_adc_valid_o = in_feed && ch_valid_i[grant];
    assign in_hs           = fft_adc_valid_o && fft_adc_ready_i;

    assign out_valid_o     = in_drain && fft_res_valid_i;
    assign fft_res_ready_o = in_drain && out_ready_i;
    assign out_data_o      = in_drain ? fft_res_data_i : '0;
    assign out_ch_o        = in_drain ? grant : '0;
    assign out_last_o      = out_valid_o && (out_cnt == CNT_MAX);
    assign out_hs          = out_valid_o && out_ready_i;

    assign busy_o = (state != IDLE);
    assign err_o  = !in_drain && fft_res_valid_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= CH_W'(NUM_CH - 1);
            in_cnt     <= '0;
            out_cnt    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (enable_i && pick_found) begin
                        grant <= pick_idx;
                        state <= FEED;
                    end
                end
                FEED: begin
                    if (in_hs) begin
                        if (in_cnt == CNT_MAX) begin
                            in_cnt <= '0;
                            state  <= DRAIN;
                        end else begin
                            in_cnt <= in_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (out_hs) begin
                        if (out_cnt == CNT_MAX) begin
                            out_cnt    <= '0;
                            in_cnt     <= '0;
                            last_grant <= grant;
                            state      <= IDLE;
                        end else begin
                            out_cnt <= out_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_arbiter.sv
// Directed bench for fft_frame_arbiter (NUM_CH=4, FFT_SIZE=8, DATA_WIDTH=16).
// Each channel is modelled as a source whose k-th sample is ch*256+k. The
// fft_core is stubbed: it accepts samples when told to and presents results
// once a full frame has been fed.
module tb_fft_frame_arbiter;

    localparam int NCH = 4;
    localparam int FS  = 8;
    localparam int DW  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic [NCH*DW-1:0] ch_data;
    logic [NCH-1:0]    ch_valid;
    logic [NCH-1:0]    ch_ready;
    logic [DW-1:0]     adc_data;
    logic              adc_valid;
    logic              adc_ready;
    logic [2*DW-1:0]   res_data;
    logic              res_valid;
    logic              res_ready;
    logic [2*DW-1:0]   out_data;
    logic [1:0]        out_ch;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              err;

    int n_checks = 0;
    int n_fail   = 0;
    int seq [NCH] = '{default: 0};

    always #5 clk = ~clk;

    fft_frame_arbiter #(.NUM_CH(NCH), .FFT_SIZE(FS), .DATA_WIDTH(DW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable),
        .ch_data_i(ch_data), .ch_valid_i(ch_valid), .ch_ready_o(ch_ready),
        .fft_adc_data_o(adc_data), .fft_adc_valid_o(adc_valid), .fft_adc_ready_i(adc_ready),
        .fft_res_data_i(res_data), .fft_res_valid_i(res_valid), .fft_res_ready_o(res_ready),
        .out_data_o(out_data), .out_ch_o(out_ch), .out_last_o(out_last),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .busy_o(busy), .err_o(err)
    );

    // Source model: present the next sample of each channel, advance on handshake.
    always_comb begin
        ch_data = '0;
        for (int k = 0; k < NCH; k++) begin
            ch_data[k*DW +: DW] = DW'(k*256 + seq[k]);
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < NCH; k++) begin
            if (ch_ready[k] && ch_valid[k]) seq[k] <= seq[k] + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; enable = 1'b0; ch_valid = '0;
        adc_ready = 1'b1; out_ready = 1'b1; res_valid = 1'b0; res_data = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Runs one frame from IDLE and reports what was observed. Counts protocol
    // violations in bad: ready on a non-granted channel, wrong sample data,
    // result fields not matching the core stub, ready not mirrored, misplaced
    // out_last, spurious err.
    task automatic run_frame(input int stall_at, input bit toggle, input int drop_en_at,
                             output int gch, output int n_in, output int n_out,
                             output int last_beat, output int bad);
        int stall_left = 3;
        int cyc = 0;
        int idx;
        logic [DW-1:0] exp_sample;
        gch = -1; n_in = 0; n_out = 0; last_beat = 0; bad = 0;
        while (n_out < FS && cyc < 200) begin
            adc_ready = !(n_in == stall_at && stall_left > 0);
            if (!adc_ready) stall_left--;
            out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            if (n_in == drop_en_at) enable = 1'b0;
            res_valid = (n_in == FS);
            res_data  = {DW'(n_out + 1), DW'(100 + n_out)};
            #1;
            if (err !== 1'b0) bad++;
            if (ch_ready != '0) begin
                idx = 0;
                for (int k = 0; k < NCH; k++) if (ch_ready[k]) idx = k;
                if ($countones(ch_ready) != 1 || n_in == FS || (gch >= 0 && idx != gch)) bad++;
                if (adc_valid && adc_ready) begin
                    if (gch < 0) gch = idx;
                    exp_sample = DW'(idx*256 + seq[idx]);
                    if (adc_data !== exp_sample) bad++;
                    n_in++;
                end
            end
            if (n_in == FS && res_valid) begin
                if (res_ready !== out_ready) bad++;
                if (out_valid !== 1'b1) bad++;
                if (out_data !== res_data) bad++;
                if (out_ch !== 2'(gch)) bad++;
                if (out_last !== (n_out == FS - 1)) bad++;
                if (out_valid && out_ready) begin
                    n_out++;
                    if (out_last) last_beat = n_out;
                end
            end else if (out_valid !== 1'b0 || res_ready !== 1'b0) begin
                bad++;
            end
            step();
            cyc++;
        end
        res_valid = 1'b0;
        out_ready = 1'b1;
        adc_ready = 1'b1;
        $display("frame: ch=%0d in=%0d out=%0d last_beat=%0d bad=%0d cycles=%0d",
                 gch, n_in, n_out, last_beat, bad, cyc);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; ch_valid = '1;
        adc_ready = 1'b1; out_ready = 1'b1; res_valid = 1'b0; res_data = '0;
        step();
        step();
        n_checks++;
        if ({busy, ch_ready, adc_valid, adc_data, out_valid, res_ready, out_data, out_ch, out_last, err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b ready=%b adc_valid=%b out_valid=%b res_ready=%b err=%b, required all 0",
                     busy, ch_ready, adc_valid, out_valid, res_ready, err);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_channel();
        int gch, n_in, n_out, lb, bad, base;
        apply_reset();
        ch_valid = 4'b0100; enable = 1'b1; base = seq[2];
        #1;
        n_checks++;
        if (adc_valid !== 1'b0 || ch_ready !== '0) begin
            n_fail++; $display("FAIL idle_no_move: adc_valid=%b ready=%b, required 0", adc_valid, ch_ready);
        end
        run_frame(-1, 1'b0, -1, gch, n_in, n_out, lb, bad);
        n_checks++; if (gch != 2) begin n_fail++; $display("FAIL single_grant: got %0d required 2", gch); end
        n_checks++; if (seq[2] - base != FS) begin n_fail++; $display("FAIL single_consumed: got %0d required %0d", seq[2] - base, FS); end
        n_checks++; if (n_out != FS) begin n_fail++; $display("FAIL single_results: got %0d required %0d", n_out, FS); end
        n_checks++; if (lb != FS) begin n_fail++; $display("FAIL single_last: got beat %0d required %0d", lb, FS); end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL single_protocol: got %0d violations required 0", bad); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: busy=%b required 0", busy); end
        ch_valid = '0;
    endtask

    task automatic test_round_robin();
        int gch, n_in, n_out, lb, bad;
        apply_reset();
        ch_valid = 4'b1111; enable = 1'b1;
        for (int f = 0; f < 5; f++) begin
            run_frame(-1, 1'b0, -1, gch, n_in, n_out, lb, bad);
            n_checks++;
            if (gch != f % NCH || n_out != FS || bad != 0) begin
                n_fail++;
                $display("FAIL rr_frame%0d: got ch=%0d out=%0d bad=%0d required ch=%0d out=%0d bad=0",
                         f, gch, n_out, bad, f % NCH, FS);
            end
        end
        ch_valid = '0;
    endtask

    task automatic test_back_pressure_in();
        int gch, n_in, n_out, lb, bad, base;
        // last_grant is 0 after the round-robin test; channel 1 is next in line.
        ch_valid = 4'b0010; base = seq[1];
        run_frame(4, 1'b0, -1, gch, n_in, n_out, lb, bad);
        n_checks++; if (gch != 1) begin n_fail++; $display("FAIL stall_grant: got %0d required 1", gch); end
        n_checks++; if (seq[1] - base != FS) begin n_fail++; $display("FAIL stall_consumed: got %0d required %0d", seq[1] - base, FS); end
        n_checks++; if (n_out != FS || bad != 0) begin n_fail++; $display("FAIL stall_frame: out=%0d bad=%0d required %0d/0", n_out, bad, FS); end
        ch_valid = '0;
    endtask

    task automatic test_back_pressure_out();
        int gch, n_in, n_out, lb, bad;
        ch_valid = 4'b0001;
        run_frame(-1, 1'b1, -1, gch, n_in, n_out, lb, bad);
        n_checks++; if (gch != 0) begin n_fail++; $display("FAIL toggle_grant: got %0d required 0", gch); end
        n_checks++; if (n_out != FS || lb != FS) begin n_fail++; $display("FAIL toggle_last: out=%0d last_beat=%0d required %0d", n_out, lb, FS); end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL toggle_protocol: got %0d violations required 0", bad); end
        ch_valid = '0;
    endtask

    task automatic test_enable_drop_and_err();
        int gch, n_in, n_out, lb, bad, waited;
        ch_valid = 4'b1000; enable = 1'b1;
        run_frame(-1, 1'b0, 3, gch, n_in, n_out, lb, bad);
        n_checks++;
        if (gch != 3 || n_out != FS || bad != 0) begin
            n_fail++; $display("FAIL enable_drop_frame: ch=%0d out=%0d bad=%0d required 3/%0d/0", gch, n_out, bad, FS);
        end
        ch_valid = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            step();
            n_checks++;
            if (busy !== 1'b0 || ch_ready !== '0) begin
                n_fail++; $display("FAIL disabled_idle: cycle %0d busy=%b ready=%b required 0", c, busy, ch_ready);
            end
        end
        enable = 1'b1;
        adc_ready = 1'b0;
        step();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reenable_grant: busy=%b required 1", busy); end
        // Core stub misbehaves during FEED.
        res_valid = 1'b1; res_data = 32'h1234_5678;
        #1;
        n_checks++;
        if (err !== 1'b1 || out_valid !== 1'b0 || res_ready !== 1'b0) begin
            n_fail++; $display("FAIL err_pulse: err=%b out_valid=%b res_ready=%b required 1/0/0", err, out_valid, res_ready);
        end
        step();
        res_valid = 1'b0;
        #1;
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL err_clear: err=%b busy=%b required 0/1", err, busy);
        end
        adc_ready = 1'b1; out_ready = 1'b1;
        waited = 0;
        while (res_ready !== 1'b1 && waited < 30) begin
            step();
            waited++;
        end
        n_checks++; if (waited >= 30) begin n_fail++; $display("FAIL reach_drain: waited %0d cycles, required <30", waited); end
        res_valid = 1'b1;
        step();
        step();
        // Reset mid-DRAIN; the core is reset alongside, so its valid drops too.
        rst_n = 1'b0; res_valid = 1'b0;
        #1;
        n_checks++;
        if ({busy, ch_ready, adc_valid, adc_data, out_valid, res_ready, out_data, out_ch, out_last, err} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_drain: busy=%b ready=%b adc_valid=%b out_valid=%b res_ready=%b required all 0",
                     busy, ch_ready, adc_valid, out_valid, res_ready);
        end
        step();
        rst_n = 1'b1;
        run_frame(-1, 1'b0, -1, gch, n_in, n_out, lb, bad);
        n_checks++;
        if (gch != 0 || n_out != FS || bad != 0) begin
            n_fail++; $display("FAIL post_reset_grant: ch=%0d out=%0d bad=%0d required 0/%0d/0", gch, n_out, bad, FS);
        end
        ch_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_round_robin();
        test_back_pressure_in();
        test_back_pressure_out();
        test_enable_drop_and_err();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
